// File: rtl/regfile_pkg.sv
// Shared defaults and types for the parameterised register file.
package regfile_pkg;
  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 5;
  localparam int INIT_R1_DEF = 7;

  typedef logic [DATA_W_DEF-1:0] word_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on
// writeback. A new issue beats a writeback to the same register in one cycle.
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  localparam int DEPTH = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic [DEPTH-1:0]  pend
);
  logic [DEPTH-1:0] pend_nxt;

  // Next pending vector: clear first so a same-register issue overrides it.
  always_comb begin
    pend_nxt = pend;
    if (we) pend_nxt[wr_addr] = 1'b0;
    if (iss_valid && iss_addr != '0) pend_nxt[iss_addr] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  // Pending state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend <= '0;
    else     pend <= pend_nxt;
  end
endmodule

// File: rtl/regfile_param.sv
// Multi-read-port register file with pending-write scoreboard and stall.
// Register 0 is hardwired to zero; register 1 resets to INIT_R1.
// Optional macro REGFILE_BYPASS_EN forwards the in-flight write to any read
// port on the same address and hides that port's busy bit.
module regfile_param import regfile_pkg::*; #(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NUM_RD  = 2,            // 2..4 read ports
  parameter int INIT_R1 = INIT_R1_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     stall,
  output logic                     eq,
  output logic [DATA_W-1:0]        outreg
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0]  mem;
  logic [DEPTH-1:0]              pend;
  logic [NUM_RD-1:0][ADDR_W-1:0] addr_v;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_word;

  assign addr_v  = rd_addr;
  assign rd_data = rd_word;

  // Storage: reset wins over any concurrent write; address 0 never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++)
        mem[k] <= (k == 1) ? DATA_W'(INIT_R1) : '0;
    end else if (we && wr_addr != '0) begin
      mem[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .wr_addr   (wr_addr),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .pend      (pend)
  );

  // Per-port combinational read and busy lookup.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [DATA_W-1:0] stored;
    assign stored = (addr_v[i] == '0) ? '0 : mem[addr_v[i]];
`ifdef REGFILE_BYPASS_EN
    logic hit;
    assign hit        = we && (wr_addr == addr_v[i]) && (addr_v[i] != '0);
    assign rd_word[i] = hit ? wr_data : stored;
    assign rd_busy[i] = pend[addr_v[i]] & ~hit;
`else
    assign rd_word[i] = stored;
    assign rd_busy[i] = pend[addr_v[i]];
`endif
  end

  assign stall  = |(rd_en & rd_busy);
  assign eq     = (rd_word[0] == rd_word[1]);
  assign outreg = mem[1];
endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 2 (range 2..4), number of read ports.
REQ-004 SHALL have parameter INIT_R1, default 7, reset value of register 1.
REQ-005 SHALL have one clock and an asynchronous, active-high reset; ports clk and rst.
REQ-006 SHALL have the following ports:
  clk  input  1  clock, all state updates on rising edge
  rst  input  1  asynchronous active-high reset
  rd_en  input  NUM_RD  per-port read-valid, used only for the stall output
  rd_addr  input  NUM_RD*ADDR_W  packed read addresses, port 0 in LSBs
  rd_data  output  NUM_RD*DATA_W  packed read data
  rd_busy  output  NUM_RD  addressed register has a pending write
  we  input  1  write enable
  wr_addr  input  ADDR_W  write address
  wr_data  input  DATA_W  write data
  iss_valid  input  1  instruction issue marks a destination pending
  iss_addr  input  ADDR_W  destination of issued instruction
  stall  output  1  OR over ports of (rd_en & rd_busy)
  eq  output  1  rd_data port 0 == rd_data port 1
  outreg  output  DATA_W  current contents of register 1 (debug)

Function
REQ-007 Reads SHALL be combinational, zero latency; no clock gating of read data.
REQ-008 Write SHALL update register wr_addr on rising clk when we=1; visible on rd_data from the next cycle (without bypass).
REQ-009 Register 0 SHALL read 0 always; writes to address 0 SHALL be ignored.
REQ-010 Scoreboard: one pending bit per register; set on rising clk when iss_valid=1 and iss_addr!=0.
REQ-011 Pending bit SHALL clear on rising clk when we=1 and wr_addr matches.
REQ-012 Simultaneous set and clear of the same register SHALL leave it set (new issue wins).
REQ-013 Pending bit of register 0 SHALL stay 0.
REQ-014 rd_busy[i] SHALL equal the pending bit of rd_addr[i], combinational.
REQ-015 eq SHALL compare full DATA_W bits of ports 0 and 1 after any bypass.
REQ-016 Multiple read ports on the same address SHALL return identical data.

Reset
REQ-017 rst=1 SHALL asynchronously set register 1 to INIT_R1, all other registers to 0, all pending bits to 0.
REQ-018 Reset asserted mid-write SHALL win; the write is lost.
REQ-019 During reset rd_busy=0, stall=0, outreg=INIT_R1.

Configuration
REQ-020 Macro REGFILE_BYPASS_EN defined: when we=1 and wr_addr==rd_addr[i]!=0, rd_data[i] SHALL equal wr_data in the same cycle, and rd_busy[i] SHALL be 0 for that port.
REQ-021 Macro undefined: rd_data reflects stored contents only; rd_busy follows REQ-014 unmodified.

Structure
REQ-022 Package regfile_pkg SHALL hold default DATA_W/ADDR_W constants, INIT_R1 default and a typedef for a register word.
REQ-023 Scoreboard SHALL be a sub-module regfile_scoreboard (pending vector, set/clear logic).

Verification
REQ-024 Reset release -> outreg=7, register 2 reads 0, rd_busy=0.
REQ-025 we=1, wr_addr=0, wr_data=FFFFFFFF -> register 0 reads 0 next cycle.
REQ-026 iss_valid, iss_addr=3; next cycle rd_addr0=3, rd_en0=1 -> rd_busy0=1, stall=1; write 3=0x55 -> next cycle busy 0, data 0x55.
REQ-027 Same cycle iss_addr=4 and we wr_addr=4 -> pending bit 4 remains 1.
REQ-028 With REGFILE_BYPASS_EN: write 5=0xA5 while rd_addr0=rd_addr1=5 -> both ports 0xA5 same cycle, eq=1, rd_busy=0.
REQ-029 rst pulsed between clock edges while we=1 to register 6 -> register 6 reads 0 after reset.
